// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: read-side handshake between a FIFO (slave) and its drain stage (master)
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_re;
  modport master (output fifo_re, input fifo_empty, fifo_data);
  modport slave (input fifo_re, output fifo_empty, fifo_data);
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and serialises them as 8N1 UART frames
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);
  typedef enum logic [2:0] {IDLE, POP, LATCH, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic last, go;
  assign last = cnt == CNT_W'(CLKS_PER_BIT - 1);
  assign go = enable && !fifo.fifo_empty;
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        state_n = go ? POP : IDLE;
        cnt_n = '0;
      end
      POP: begin
        state_n = LATCH;
        cnt_n = '0;
      end
      LATCH: begin
        state_n = START;
        cnt_n = '0;
        idx_n = '0;
        shift_n = fifo.fifo_data;
      end
      START: state_n = last ? DATA : START;
      DATA: if (last) begin
        shift_n = shift >> 1;
        idx_n = idx + 1'b1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (last) state_n = go ? POP : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      fifo.fifo_re <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      tx <= state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;
      busy <= state_n != IDLE;
      fifo.fifo_re <= state_n == POP;
      frame_done <= state_n == STOP && cnt_n == CNT_W'(CLKS_PER_BIT - 1);
    end
endmodule
